// File: rtl/sfx_sequencer_if.sv
// Trigger/control and synth-drive signals between game logic and the sound-effect sequencer.
// The master side raises triggers and mute; the slave (sequencer) drives the synth controls.
interface sfx_sequencer_if;
  logic        trig_wall;
  logic        trig_paddle;
  logic        trig_brick;
  logic        trig_lose;
  logic        mute;
  logic        tick;
  logic        enable;
  logic [15:0] half_period;
  logic        busy;

  modport master (
    output trig_wall, trig_paddle, trig_brick, trig_lose, mute,
    input  tick, enable, half_period, busy
  );

  modport slave (
    input  trig_wall, trig_paddle, trig_brick, trig_lose, mute,
    output tick, enable, half_period, busy
  );
endinterface

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: plays short note sequences from an internal ROM on game-event
// triggers, with priority preemption, mute abort and a free-running synth tick prescaler.
module sfx_sequencer #(
  parameter int unsigned TickDiv = 50,
  parameter int unsigned MsDiv   = 50000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  sfx_sequencer_if.slave bus_io
);

  localparam int unsigned TickW = $clog2(TickDiv);
  localparam int unsigned MsW   = $clog2(MsDiv);
  localparam logic [TickW-1:0] TickLast = TickW'(TickDiv - 1);
  localparam logic [MsW-1:0]   MsLast   = MsW'(MsDiv - 1);

  localparam logic [1:0] FxWall   = 2'd0;
  localparam logic [1:0] FxPaddle = 2'd1;
  localparam logic [1:0] FxBrick  = 2'd2;
  localparam logic [1:0] FxLose   = 2'd3;

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  typedef struct packed {
    logic        last;
    logic [15:0] hp;
    logic [7:0]  dur;
  } note_t;

  function automatic note_t note_rom(input logic [1:0] fx, input logic [1:0] idx);
    note_t n;
    unique case ({fx, idx})
      {FxWall,   2'd0}: n = '{last: 1'b1, hp: 16'd1000, dur: 8'd20};
      {FxPaddle, 2'd0}: n = '{last: 1'b1, hp: 16'd500,  dur: 8'd30};
      {FxBrick,  2'd0}: n = '{last: 1'b0, hp: 16'd400,  dur: 8'd20};
      {FxBrick,  2'd1}: n = '{last: 1'b1, hp: 16'd300,  dur: 8'd40};
      {FxLose,   2'd0}: n = '{last: 1'b0, hp: 16'd1500, dur: 8'd100};
      {FxLose,   2'd1}: n = '{last: 1'b0, hp: 16'd2000, dur: 8'd100};
      {FxLose,   2'd2}: n = '{last: 1'b1, hp: 16'd3000, dur: 8'd200};
      default:          n = '{last: 1'b1, hp: 16'd0,    dur: 8'd1};
    endcase
    return n;
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       fx_q, fx_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      hp_q, hp_d;
  logic [MsW-1:0]   ms_q, ms_d;
  logic [7:0]       dur_q, dur_d;
  logic [TickW-1:0] tick_cnt_q;

  logic       trig_vld;
  logic [1:0] trig_fx;
  logic       accept;
  note_t      note;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_cnt_q <= '0;
    end else if (tick_cnt_q == TickLast) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  always_comb begin
    trig_vld = bus_io.trig_wall | bus_io.trig_paddle | bus_io.trig_brick | bus_io.trig_lose;
    if (bus_io.trig_lose)        trig_fx = FxLose;
    else if (bus_io.trig_brick)  trig_fx = FxBrick;
    else if (bus_io.trig_paddle) trig_fx = FxPaddle;
    else                         trig_fx = FxWall;
    accept = ~bus_io.mute & trig_vld & ((state_q == StIdle) | (trig_fx >= fx_q));
  end

  // One ROM port: addresses the incoming effect's first note on accept, else the current note.
  assign note = accept ? note_rom(trig_fx, 2'd0) : note_rom(fx_q, idx_q);

  always_comb begin
    state_d = state_q;
    fx_d    = fx_q;
    idx_d   = idx_q;
    hp_d    = hp_q;
    ms_d    = ms_q;
    dur_d   = dur_q;
    if (bus_io.mute) begin
      state_d = StIdle;
      idx_d   = 2'd0;
      hp_d    = '0;
      ms_d    = '0;
      dur_d   = '0;
    end else if (accept) begin
      fx_d  = trig_fx;
      idx_d = 2'd0;
      ms_d  = '0;
      dur_d = '0;
      if (state_q == StIdle) begin
        state_d = StPlay;
        hp_d    = note.hp;
      end else begin
        // Preempt through a one-cycle gap so the synth phase restarts cleanly.
        state_d = StGap;
      end
    end else begin
      unique case (state_q)
        StPlay: begin
          if (ms_q == MsLast) begin
            ms_d = '0;
            if (dur_q == note.dur - 8'd1) begin
              dur_d = '0;
              if (note.last) begin
                state_d = StIdle;
                hp_d    = '0;
              end else begin
                state_d = StGap;
                idx_d   = idx_q + 2'd1;
              end
            end else begin
              dur_d = dur_q + 8'd1;
            end
          end else begin
            ms_d = ms_q + 1'b1;
          end
        end
        StGap: begin
          state_d = StPlay;
          hp_d    = note.hp;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      fx_q    <= FxWall;
      idx_q   <= 2'd0;
      hp_q    <= '0;
      ms_q    <= '0;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      fx_q    <= fx_d;
      idx_q   <= idx_d;
      hp_q    <= hp_d;
      ms_q    <= ms_d;
      dur_q   <= dur_d;
    end
  end

  assign bus_io.tick        = (tick_cnt_q == TickLast);
  assign bus_io.enable      = (state_q == StPlay);
  assign bus_io.busy        = (state_q != StIdle);
  assign bus_io.half_period = hp_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Scoreboard bench for sfx_sequencer: expected per-cycle synth outputs are queued when a
// trigger is driven and popped against the DUT every cycle; TICK is tracked by its own counter.
module tb_sfx_sequencer;
  localparam int TickDiv = 5;
  localparam int MsDiv   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sfx_sequencer_if sfx_if ();

  sfx_sequencer #(
    .TickDiv(TickDiv),
    .MsDiv  (MsDiv)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(sfx_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [15:0] hp;
    logic        busy;
    logic        hp_care;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc      = 0;
  int    tk_cnt   = 0;
  string cur_test = "init";

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s cycle %0d: got %0d expected %0d", cur_test, tag, cyc, got, exp);
    end
  endtask

  function automatic int fx_hp(input int fx, input int i);
    case (fx * 4 + i)
      0:       return 1000;
      4:       return 500;
      8:       return 400;
      9:       return 300;
      12:      return 1500;
      13:      return 2000;
      14:      return 3000;
      default: return 0;
    endcase
  endfunction

  function automatic int fx_dur(input int fx, input int i);
    case (fx * 4 + i)
      0:       return 20;
      4:       return 30;
      8:       return 20;
      9:       return 40;
      12:      return 100;
      13:      return 100;
      14:      return 200;
      default: return 0;
    endcase
  endfunction

  function automatic int fx_notes(input int fx);
    case (fx)
      0, 1:    return 1;
      2:       return 2;
      default: return 3;
    endcase
  endfunction

  task automatic push(input logic en, input int hp, input logic busy, input logic care,
                      input int n);
    exp_t e;
    e.en      = en;
    e.hp      = 16'(hp);
    e.busy    = busy;
    e.hp_care = care;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // Full playback of an effect starting with its first note: notes joined by 1-cycle gaps.
  task automatic push_effect(input int fx);
    for (int i = 0; i < fx_notes(fx); i++) begin
      if (i > 0) push(1'b0, fx_hp(fx, i - 1), 1'b1, 1'b1, 1);
      push(1'b1, fx_hp(fx, i), 1'b1, 1'b1, fx_dur(fx, i) * MsDiv);
    end
  endtask

  task automatic cycle_end();
    exp_t e;
    @(negedge clk);
    check_eq("tick", 32'(sfx_if.tick), 32'(tk_cnt == TickDiv - 1));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("enable", 32'(sfx_if.enable), 32'(e.en));
      check_eq("busy", 32'(sfx_if.busy), 32'(e.busy));
      if (e.hp_care) check_eq("half_period", 32'(sfx_if.half_period), 32'(e.hp));
    end
    tk_cnt = rst ? 0 : (tk_cnt + 1) % TickDiv;
    @(posedge clk);
    #1;
    sfx_if.trig_wall   = 1'b0;
    sfx_if.trig_paddle = 1'b0;
    sfx_if.trig_brick  = 1'b0;
    sfx_if.trig_lose   = 1'b0;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle_end();
  endtask

  task automatic drain();
    while (exp_q.size() > 0) cycle_end();
  endtask

  task automatic do_reset(input string name);
    cur_test = name;
    exp_q.delete();
    rst = 1'b1;
    sfx_if.mute = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    cyc    = 0;
    tk_cnt = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    sfx_if.trig_wall   = 1'b0;
    sfx_if.trig_paddle = 1'b0;
    sfx_if.trig_brick  = 1'b0;
    sfx_if.trig_lose   = 1'b0;
    sfx_if.mute        = 1'b0;

    do_reset("reset");
    push(1'b0, 0, 1'b0, 1'b1, 15);
    drain();

    do_reset("wall");
    sfx_if.trig_wall = 1'b1;
    push(1'b0, 0, 1'b0, 1'b1, 1);
    push_effect(0);
    push(1'b0, 0, 1'b0, 1'b1, 3);
    drain();

    do_reset("brick");
    sfx_if.trig_brick = 1'b1;
    push(1'b0, 0, 1'b0, 1'b1, 1);
    push_effect(2);
    push(1'b0, 0, 1'b0, 1'b1, 3);
    drain();

    do_reset("brick_wall_drop");
    sfx_if.trig_brick = 1'b1;
    push(1'b0, 0, 1'b0, 1'b1, 1);
    push_effect(2);
    push(1'b0, 0, 1'b0, 1'b1, 3);
    run(10);
    sfx_if.trig_wall = 1'b1;
    drain();

    do_reset("brick_lose_preempt");
    sfx_if.trig_brick = 1'b1;
    push(1'b0, 0, 1'b0, 1'b1, 1);
    push(1'b1, 400, 1'b1, 1'b1, 10);
    push(1'b0, 0, 1'b1, 1'b0, 1);
    push_effect(3);
    push(1'b0, 0, 1'b0, 1'b1, 3);
    run(10);
    sfx_if.trig_lose = 1'b1;
    drain();

    do_reset("simultaneous");
    sfx_if.trig_wall   = 1'b1;
    sfx_if.trig_paddle = 1'b1;
    sfx_if.trig_lose   = 1'b1;
    push(1'b0, 0, 1'b0, 1'b1, 1);
    push_effect(3);
    push(1'b0, 0, 1'b0, 1'b1, 3);
    drain();

    do_reset("paddle_restart");
    sfx_if.trig_paddle = 1'b1;
    push(1'b0, 0, 1'b0, 1'b1, 1);
    push(1'b1, 500, 1'b1, 1'b1, 20);
    push(1'b0, 500, 1'b1, 1'b1, 1);
    push_effect(1);
    push(1'b0, 0, 1'b0, 1'b1, 3);
    run(20);
    sfx_if.trig_paddle = 1'b1;
    drain();

    do_reset("reset_mid");
    sfx_if.trig_lose = 1'b1;
    push(1'b0, 0, 1'b0, 1'b1, 1);
    push(1'b1, 1500, 1'b1, 1'b1, 50);
    push(1'b0, 0, 1'b0, 1'b1, 30);
    run(50);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    drain();

    do_reset("mute_mid");
    sfx_if.trig_lose = 1'b1;
    push(1'b0, 0, 1'b0, 1'b1, 1);
    push(1'b1, 1500, 1'b1, 1'b1, 50);
    push(1'b0, 0, 1'b0, 1'b1, 30);
    run(50);
    sfx_if.mute      = 1'b1;
    sfx_if.trig_lose = 1'b1;
    run(10);
    sfx_if.trig_paddle = 1'b1;
    drain();
    sfx_if.mute = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
